extbus_vram_ctrl: RTL and testbench

EXTBUS_VRAM_CTRL -- requirements
Module: extbus_vram_ctrl

---
 rtl/extbus_pkg.sv | 56 +++++
 rtl/extbus_sync.sv | 70 +++++++
 rtl/extbus_vram_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_extbus_vram_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/extbus_pkg.sv
// Shared definitions for the external-bus VRAM controller:
// register map, pointer step table, FSM state encoding.
package extbus_pkg;

    localparam logic [4:0] REG_ADDR_L = 5'd0;
    localparam logic [4:0] REG_ADDR_M = 5'd1;
    localparam logic [4:0] REG_ADDR_H = 5'd2;
    localparam logic [4:0] REG_DATA0  = 5'd3;
    localparam logic [4:0] REG_DATA1  = 5'd4;
    localparam logic [4:0] REG_CTRL   = 5'd5;

    localparam int CTRL_ADDRSEL = 0;
    localparam int CTRL_OVERRUN = 6;
    localparam int CTRL_SOFTRST = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;

    typedef struct packed {
        logic [16:0] addr;
        logic [3:0]  incr;
        logic        decr;
    } vptr_t;

    function automatic logic [16:0] incr_step(input logic [3:0] incr);
        logic [16:0] s;
        case (incr)
            4'd0:    s = 17'd0;
            4'd1:    s = 17'd1;
            4'd2:    s = 17'd2;
            4'd3:    s = 17'd4;
            4'd4:    s = 17'd8;
            4'd5:    s = 17'd16;
            4'd6:    s = 17'd32;
            4'd7:    s = 17'd64;
            4'd8:    s = 17'd128;
            4'd9:    s = 17'd256;
            4'd10:   s = 17'd512;
            4'd11:   s = 17'd40;
            4'd12:   s = 17'd80;
            4'd13:   s = 17'd160;
            4'd14:   s = 17'd320;
            default: s = 17'd640;
        endcase
        return s;
    endfunction

    // 17-bit result, so both directions wrap modulo 2^17.
    function automatic logic [16:0] ptr_next(input vptr_t p);
        logic [16:0] step;
        step = incr_step(p.incr);
        return p.decr ? (p.addr - step) : (p.addr + step);
    endfunction

endpackage

// File: rtl/extbus_sync.sv
// Two-flop synchronizer for the asynchronous host bus plus strobe
// edge detection.
// Ports: clk/rst; raw cs_n, rd_n, wr_n, a, d in; synchronized
// cs_n_s, rd_n_s, a_s out; wr_stb/rd_stb pulse one cycle on the
// synchronized strobe rising edge (cs_n low the prior cycle), with
// stb_a/stb_d holding address/data from that prior cycle.
module extbus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [4:0] a,
    input  logic [7:0] d,
    output logic       cs_n_s,
    output logic       rd_n_s,
    output logic [4:0] a_s,
    output logic       wr_stb,
    output logic       rd_stb,
    output logic [4:0] stb_a,
    output logic [7:0] stb_d
);

    logic       cs_m, rd_m, wr_m;
    logic [4:0] a_m;
    logic [7:0] d_m;
    logic       wr_n_s;
    logic [7:0] d_s;
    logic       cs_p, rd_p, wr_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_m   <= 1'b1;
            rd_m   <= 1'b1;
            wr_m   <= 1'b1;
            a_m    <= '0;
            d_m    <= '0;
            cs_n_s <= 1'b1;
            rd_n_s <= 1'b1;
            wr_n_s <= 1'b1;
            a_s    <= '0;
            d_s    <= '0;
            cs_p   <= 1'b1;
            rd_p   <= 1'b1;
            wr_p   <= 1'b1;
            stb_a  <= '0;
            stb_d  <= '0;
        end else begin
            cs_m   <= cs_n;
            rd_m   <= rd_n;
            wr_m   <= wr_n;
            a_m    <= a;
            d_m    <= d;
            cs_n_s <= cs_m;
            rd_n_s <= rd_m;
            wr_n_s <= wr_m;
            a_s    <= a_m;
            d_s    <= d_m;
            cs_p   <= cs_n_s;
            rd_p   <= rd_n_s;
            wr_p   <= wr_n_s;
            stb_a  <= a_s;
            stb_d  <= d_s;
        end
    end

    assign wr_stb = wr_n_s && !wr_p && !cs_p;
    assign rd_stb = rd_n_s && !rd_p && !cs_p;

endmodule

// File: rtl/extbus_vram_ctrl.sv
// Host-bus register window onto a 128 KiB VRAM with two auto-stepping
// pointers, per-port prefetch latches and a single-outstanding master.
// Ports: clk, rst (sync, active-high); extbus_cs_n/rd_n/wr_n/a/d_in
// async host bus in, extbus_d_out/d_oe read data out; vram_req/we/
// addr/wdata request out, vram_ack/rdata completion in.
module extbus_vram_ctrl
    import extbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        extbus_cs_n,
    input  logic        extbus_rd_n,
    input  logic        extbus_wr_n,
    input  logic [4:0]  extbus_a,
    input  logic [7:0]  extbus_d_in,
    output logic [7:0]  extbus_d_out,
    output logic        extbus_d_oe,
    output logic        vram_req,
    output logic        vram_we,
    output logic [16:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata
);

    logic       cs_n_s, rd_n_s;
    logic [4:0] a_s;
    logic       wr_stb, rd_stb;
    logic [4:0] stb_a;
    logic [7:0] stb_d;

    extbus_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .cs_n   (extbus_cs_n),
        .rd_n   (extbus_rd_n),
        .wr_n   (extbus_wr_n),
        .a      (extbus_a),
        .d      (extbus_d_in),
        .cs_n_s (cs_n_s),
        .rd_n_s (rd_n_s),
        .a_s    (a_s),
        .wr_stb (wr_stb),
        .rd_stb (rd_stb),
        .stb_a  (stb_a),
        .stb_d  (stb_d)
    );

    vptr_t       ptr      [0:1];
    logic [16:0] wr_addr  [0:1];
    logic [7:0]  wr_data  [0:1];
    logic [7:0]  latch    [0:1];
    logic [1:0]  wr_pend;
    logic [1:0]  fetch_pend;
    logic        addrsel;
    logic        overrun;
    logic        soft_rst;
    logic [1:0]  state;
    logic        cur_port;
    logic        stale;

    logic        go, go_we, go_port;
    logic        ptr_reg_wr;
    logic        data_acc, data_port;
    logic        data_ok, data_ovr;
    logic [1:0]  busy;
    logic        fetch_live, live_port;
    logic        flush;
    logic        fetch_ack;
    logic [7:0]  rd_mux;

    always_comb begin
        go      = 1'b0;
        go_we   = 1'b0;
        go_port = 1'b0;
        if (state == ST_IDLE) begin
            if (wr_pend[0]) begin
                go    = 1'b1;
                go_we = 1'b1;
            end else if (wr_pend[1]) begin
                go      = 1'b1;
                go_we   = 1'b1;
                go_port = 1'b1;
            end else if (fetch_pend[0]) begin
                go = 1'b1;
            end else if (fetch_pend[1]) begin
                go      = 1'b1;
                go_port = 1'b1;
            end
        end
    end

    assign busy       = wr_pend | fetch_pend;
    assign ptr_reg_wr = wr_stb && (stb_a == REG_ADDR_L ||
                                   stb_a == REG_ADDR_M ||
                                   stb_a == REG_ADDR_H);
    assign data_acc   = (wr_stb || rd_stb) &&
                        (stb_a == REG_DATA0 || stb_a == REG_DATA1);
    assign data_port  = (stb_a == REG_DATA1);
    assign data_ok    = data_acc && !busy[data_port];
    assign data_ovr   = data_acc && busy[data_port];

    // A fetch is "live" from the cycle it is issued until its ack; a
    // pointer rewrite during that window makes its data stale.
    assign fetch_live = (state == ST_FETCH) || (go && !go_we);
    assign live_port  = (state == ST_IDLE) ? go_port : cur_port;
    assign flush      = ptr_reg_wr && fetch_live && (live_port == addrsel);
    assign fetch_ack  = (state == ST_FETCH) && vram_ack;

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            for (int i = 0; i < 2; i++) begin
                ptr[i]     <= '0;
                wr_addr[i] <= '0;
                wr_data[i] <= '0;
                latch[i]   <= '0;
            end
            wr_pend    <= '0;
            fetch_pend <= '0;
            addrsel    <= 1'b0;
            overrun    <= 1'b0;
            soft_rst   <= 1'b0;
            state      <= ST_IDLE;
            cur_port   <= 1'b0;
            stale      <= 1'b0;
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        vram_req <= 1'b1;
                        vram_we  <= go_we;
                        cur_port <= go_port;
                        if (go_we) begin
                            vram_addr  <= wr_addr[go_port];
                            vram_wdata <= wr_data[go_port];
                            state      <= ST_WRITE;
                        end else begin
                            vram_addr <= ptr[go_port].addr;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_WRITE: begin
                    if (vram_ack) begin
                        vram_req          <= 1'b0;
                        vram_we           <= 1'b0;
                        wr_pend[cur_port] <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        stale    <= 1'b0;
                        state    <= ST_IDLE;
                        // Stale data is dropped and the pending flag
                        // is kept so the fetch goes out again.
                        if (!(stale || flush)) begin
                            latch[cur_port]      <= vram_rdata;
                            fetch_pend[cur_port] <= 1'b0;
                        end
                    end
                end
                default: begin
                    vram_req <= 1'b0;
                    vram_we  <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase

            if (flush && !fetch_ack)
                stale <= 1'b1;

            if (wr_stb) begin
                unique case (stb_a)
                    REG_ADDR_L: begin
                        ptr[addrsel].addr[7:0] <= stb_d;
                        fetch_pend[addrsel]    <= 1'b1;
                    end
                    REG_ADDR_M: begin
                        ptr[addrsel].addr[15:8] <= stb_d;
                        fetch_pend[addrsel]     <= 1'b1;
                    end
                    REG_ADDR_H: begin
                        ptr[addrsel].incr     <= stb_d[7:4];
                        ptr[addrsel].decr     <= stb_d[3];
                        ptr[addrsel].addr[16] <= stb_d[0];
                        fetch_pend[addrsel]   <= 1'b1;
                    end
                    REG_CTRL: begin
                        addrsel  <= stb_d[CTRL_ADDRSEL];
                        soft_rst <= stb_d[CTRL_SOFTRST];
                        if (stb_d[CTRL_OVERRUN])
                            overrun <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (data_ovr)
                overrun <= 1'b1;

            if (data_ok) begin
                if (wr_stb) begin
                    wr_pend[data_port] <= 1'b1;
                    wr_addr[data_port] <= ptr[data_port].addr;
                    wr_data[data_port] <= stb_d;
                end
                ptr[data_port].addr   <= ptr_next(ptr[data_port]);
                fetch_pend[data_port] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (a_s)
            REG_ADDR_L: rd_mux = ptr[addrsel].addr[7:0];
            REG_ADDR_M: rd_mux = ptr[addrsel].addr[15:8];
            REG_ADDR_H: rd_mux = {ptr[addrsel].incr,
                                  ptr[addrsel].decr,
                                  2'b00,
                                  ptr[addrsel].addr[16]};
            REG_DATA0:  rd_mux = latch[0];
            REG_DATA1:  rd_mux = latch[1];
            REG_CTRL:   rd_mux = {1'b0, overrun, 5'b0, addrsel};
            default:    rd_mux = '0;
        endcase
    end

    assign extbus_d_oe  = !cs_n_s && !rd_n_s;
    assign extbus_d_out = extbus_d_oe ? rd_mux : 8'h00;

endmodule

// File: tb/tb_extbus_vram_ctrl.sv
// Randomized and directed bench for extbus_vram_ctrl against a
// register-level model with its own VRAM image.
module tb_extbus_vram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, rd_n, wr_n;
    logic [4:0]  a;
    logic [7:0]  d_in, d_out;
    logic        d_oe;
    logic        vram_req, vram_we, vram_ack;
    logic [16:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;

    extbus_vram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .extbus_cs_n  (cs_n),
        .extbus_rd_n  (rd_n),
        .extbus_wr_n  (wr_n),
        .extbus_a     (a),
        .extbus_d_in  (d_in),
        .extbus_d_out (d_out),
        .extbus_d_oe  (d_oe),
        .vram_req     (vram_req),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_wdata   (vram_wdata),
        .vram_ack     (vram_ack),
        .vram_rdata   (vram_rdata)
    );

    always #20 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] vram_init(input int ad);
        logic [16:0] x;
        x = 17'(ad);
        return x[7:0] ^ x[15:8] ^ {7'b0, x[16]} ^ 8'h5A;
    endfunction

    logic [7:0]  vram [int];
    logic [24:0] got_wr [$];
    logic [16:0] got_fetch [$];
    bit          stall = 1'b0;

    initial begin
        vram_ack   = 1'b0;
        vram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (vram_req === 1'b1) begin
                int dly;
                dly = stall ? 20 : int'($urandom_range(0, 3));
                repeat (dly) @(negedge clk);
                if (vram_req === 1'b1) begin
                    if (vram_we) begin
                        vram[int'(vram_addr)] = vram_wdata;
                        got_wr.push_back({vram_addr, vram_wdata});
                        vram_rdata = 8'($urandom);
                    end else begin
                        vram_rdata = vram.exists(int'(vram_addr)) ?
                            vram[int'(vram_addr)] : vram_init(int'(vram_addr));
                        got_fetch.push_back(vram_addr);
                    end
                    vram_ack = 1'b1;
                    @(negedge clk);
                    vram_ack = 1'b0;
                end
            end
        end
    end

    // Reference model: register-level view of the block.
    int          steps [16] = '{0, 1, 2, 4, 8, 16, 32, 64, 128,
                                256, 512, 40, 80, 160, 320, 640};
    logic [16:0] m_ptr   [2];
    logic [3:0]  m_incr  [2];
    logic        m_decr  [2];
    logic [7:0]  m_latch [2];
    bit          busy_n  [2];
    logic        m_sel, m_ovr;
    logic [7:0]  m_mem [int];
    logic [24:0] exp_wr [$];
    logic [16:0] exp_fetch [$];

    function automatic logic [7:0] m_rdmem(input int ad);
        return m_mem.exists(ad) ? m_mem[ad] : vram_init(ad);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i]   = '0;
            m_incr[i]  = '0;
            m_decr[i]  = 1'b0;
            m_latch[i] = '0;
            busy_n[i]  = 1'b0;
        end
        m_sel = 1'b0;
        m_ovr = 1'b0;
        exp_wr.delete();
        exp_fetch.delete();
    endtask

    task automatic m_refetch(input int n);
        m_latch[n] = m_rdmem(int'(m_ptr[n]));
        exp_fetch.push_back(m_ptr[n]);
    endtask

    task automatic m_advance(input int n);
        if (m_decr[n])
            m_ptr[n] = 17'(int'(m_ptr[n]) - steps[m_incr[n]]);
        else
            m_ptr[n] = 17'(int'(m_ptr[n]) + steps[m_incr[n]]);
    endtask

    function automatic logic [7:0] m_rdval(input logic [4:0] ad);
        case (ad)
            5'd0: return m_ptr[m_sel][7:0];
            5'd1: return m_ptr[m_sel][15:8];
            5'd2: return {m_incr[m_sel], m_decr[m_sel], 2'b00, m_ptr[m_sel][16]};
            5'd3: return m_latch[0];
            5'd4: return m_latch[1];
            5'd5: return {1'b0, m_ovr, 5'b0, m_sel};
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_write(input logic [4:0] ad, input logic [7:0] dd);
        int n;
        n = int'(m_sel);
        case (ad)
            5'd0: begin m_ptr[n][7:0] = dd; m_refetch(n); end
            5'd1: begin m_ptr[n][15:8] = dd; m_refetch(n); end
            5'd2: begin
                m_incr[n]     = dd[7:4];
                m_decr[n]     = dd[3];
                m_ptr[n][16]  = dd[0];
                m_refetch(n);
            end
            5'd3, 5'd4: begin
                n = int'(ad) - 3;
                if (busy_n[n]) begin
                    m_ovr = 1'b1;
                end else begin
                    m_mem[int'(m_ptr[n])] = dd;
                    exp_wr.push_back({m_ptr[n], dd});
                    m_advance(n);
                    m_refetch(n);
                end
            end
            5'd5: begin
                if (dd[7]) begin
                    m_reset();
                end else begin
                    m_sel = dd[0];
                    if (dd[6]) m_ovr = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic m_read_effect(input logic [4:0] ad);
        int n;
        if (ad == 5'd3 || ad == 5'd4) begin
            n = int'(ad) - 3;
            if (busy_n[n]) begin
                m_ovr = 1'b1;
            end else begin
                m_advance(n);
                m_refetch(n);
            end
        end
    endtask

    task automatic bus_write(input logic [4:0] ad, input logic [7:0] dd);
        @(negedge clk);
        a = ad; d_in = dd; cs_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b0;
        repeat (3) @(negedge clk);
        wr_n = 1'b1;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_read(input logic [4:0] ad, output logic [7:0] v,
                            output logic oe);
        @(negedge clk);
        a = ad; cs_n = 1'b0;
        @(negedge clk);
        rd_n = 1'b0;
        repeat (4) @(negedge clk);
        v  = d_out;
        oe = d_oe;
        rd_n = 1'b1;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        int quiet, t;
        quiet = 0;
        t = 0;
        while (quiet < 4 && t < 400) begin
            @(negedge clk);
            t++;
            quiet = (vram_req === 1'b1) ? 0 : quiet + 1;
        end
        check("vram_idle", quiet >= 4, 1);
        check("wr_count", got_wr.size(), exp_wr.size());
        while (got_wr.size() > 0 && exp_wr.size() > 0)
            check("wr_op", got_wr.pop_front(), exp_wr.pop_front());
        check("fetch_count", got_fetch.size(), exp_fetch.size());
        while (got_fetch.size() > 0 && exp_fetch.size() > 0)
            check("fetch_addr", got_fetch.pop_front(), exp_fetch.pop_front());
        got_wr.delete();
        got_fetch.delete();
        exp_wr.delete();
        exp_fetch.delete();
        busy_n[0] = 1'b0;
        busy_n[1] = 1'b0;
    endtask

    task automatic op_wr(input logic [4:0] ad, input logic [7:0] dd,
                         input bit wait_done = 1'b1);
        bus_write(ad, dd);
        m_write(ad, dd);
        if (wait_done) begin
            settle();
        end else if (ad <= 5'd2) begin
            busy_n[m_sel] = 1'b1;
        end else if (ad == 5'd3 || ad == 5'd4) begin
            busy_n[int'(ad) - 3] = 1'b1;
        end
    endtask

    task automatic op_rd(input logic [4:0] ad, output logic [7:0] v);
        logic oe;
        bus_read(ad, v, oe);
        check("d_oe", oe, 1);
        check($sformatf("rd_reg%0d", ad), v, m_rdval(ad));
        m_read_effect(ad);
        settle();
    endtask

    task automatic rd_ptr(output logic [16:0] p);
        logic [7:0] l, m, h;
        logic oe;
        bus_read(5'd0, l, oe);
        bus_read(5'd1, m, oe);
        bus_read(5'd2, h, oe);
        p = {h[0], m, l};
    endtask

    logic [7:0]  rv;
    logic [16:0] pv;
    logic [7:0]  pat [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    initial begin
        rst = 1'b1;
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        a = '0; d_in = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_d_oe", d_oe, 0);
        check("rst_req", vram_req, 0);
        check("rst_we", vram_we, 0);
        check("rst_addr", vram_addr, 0);
        for (int r = 0; r < 8; r++) op_rd(5'(r), rv);

        op_wr(5'd5, 8'h00);
        op_wr(5'd0, 8'h00);
        op_wr(5'd1, 8'h40);
        op_wr(5'd2, 8'h10);
        rd_ptr(pv);
        check("ptr_set", pv, 17'h04000);

        for (int i = 0; i < 4; i++) op_wr(5'd3, pat[i]);
        rd_ptr(pv);
        check("ptr_after_wr", pv, 17'h04004);

        op_wr(5'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            op_rd(5'd3, rv);
            check("data0_pat", rv, pat[i]);
        end
        rd_ptr(pv);
        check("ptr_after_rd", pv, 17'h04004);

        op_wr(5'd2, 8'h19);
        op_wr(5'd1, 8'h00);
        op_wr(5'd0, 8'h00);
        op_wr(5'd3, 8'h5E);
        rd_ptr(pv);
        check("ptr_wrap_dn", pv, 17'h0FFFF);

        op_wr(5'd2, 8'hB1);
        op_wr(5'd1, 8'hFF);
        op_wr(5'd0, 8'hF0);
        op_wr(5'd3, 8'h77);
        rd_ptr(pv);
        check("ptr_wrap_up", pv, 17'h00018);

        op_wr(5'd2, 8'h18);
        op_wr(5'd1, 8'h00);
        op_wr(5'd0, 8'h00);
        op_rd(5'd3, rv);
        rd_ptr(pv);
        check("ptr_zero_m1", pv, 17'h1FFFF);

        op_wr(5'd2, 8'h10);
        op_wr(5'd1, 8'h20);
        op_wr(5'd0, 8'h00);
        stall = 1'b1;
        op_wr(5'd3, 8'hC1, 1'b0);
        op_wr(5'd3, 8'hC2, 1'b0);
        stall = 1'b0;
        op_rd(5'd5, rv);
        check("ovr_set", rv, 8'h40);
        rd_ptr(pv);
        check("ptr_held", pv, 17'h02001);
        op_wr(5'd5, 8'h40);
        op_rd(5'd5, rv);
        check("ovr_clr", rv, 8'h00);

        op_wr(5'd5, 8'h01);
        op_wr(5'd2, 8'h31);
        op_wr(5'd1, 8'h23);
        op_wr(5'd0, 8'h45);
        op_wr(5'd4, 8'h5C);
        op_wr(5'd4, 8'h6D);
        op_wr(5'd0, 8'h45);
        op_rd(5'd4, rv);
        check("data1_rd", rv, 8'h5C);

        stall = 1'b1;
        op_wr(5'd0, 8'h33, 1'b0);
        stall = 1'b0;
        op_wr(5'd5, 8'h80, 1'b0);
        check("srst_req", vram_req, 0);
        repeat (25) @(negedge clk);
        settle();
        for (int r = 0; r < 8; r++) begin
            op_rd(5'(r), rv);
            check("srst_zero", rv, 8'h00);
        end

        for (int k = 0; k < 80; k++) begin
            logic [4:0] ra;
            logic [7:0] rd;
            ra = 5'($urandom_range(0, 7));
            rd = 8'($urandom);
            if (ra == 5'd5) rd = rd & 8'h41;
            if ($urandom_range(0, 1) == 0) op_wr(ra, rd);
            else op_rd(ra, rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
